// File: rtl/spio_uart_tx_scheduler.sv
// Byte scheduler for the SpiNNaker UART link: sends framing sync sequences
// (N x 8'h00 then 8'hFF) and serialises packets LSB-first into a byte stream.
`ifndef PKT_LEN
`define PKT_LEN 72
`endif

module spio_uart_tx_scheduler #(
    parameter int unsigned NUM_SYNC_NULLS = 16,
    parameter int unsigned SYNC_INTERVAL  = 0
) (
    input  logic                CLK_IN,
    input  logic                RESET_IN,
    input  logic [`PKT_LEN-1:0] PKT_DATA_IN,
    input  logic                PKT_VLD_IN,
    output logic                PKT_RDY_OUT,
    input  logic                SYNC_REQ_IN,
    output logic [7:0]          BYTE_DATA_OUT,
    output logic                BYTE_VLD_OUT,
    input  logic                BYTE_RDY_IN,
    output logic                SYNCHRONISING_OUT
);
    localparam int unsigned PKT_W       = `PKT_LEN;
    localparam int unsigned NULL_W      = 8;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned IVL_W       = 24;
    localparam int unsigned SHORT_BYTES = 5;
    localparam int unsigned LONG_BYTES  = 9;

    localparam logic [NULL_W-1:0] LAST_NULL  = NULL_W'(NUM_SYNC_NULLS - 1);
    localparam logic [IDX_W-1:0]  LAST_SHORT = IDX_W'(SHORT_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_LONG  = IDX_W'(LONG_BYTES - 1);
    localparam logic [IVL_W-1:0]  IVL_LAST   = IVL_W'(SYNC_INTERVAL - 1);
    localparam logic              IVL_EN     = (SYNC_INTERVAL != 0);

    typedef enum logic [2:0] {
        SYNC_NULL = 3'd0,
        SYNC_FF   = 3'd1,
        IDLE      = 3'd2,
        PKT       = 3'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NULL_W-1:0]  r_null_cnt;
    logic [NULL_W-1:0]  w_null_cnt_nxt;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [IDX_W-1:0]   w_byte_idx_nxt;
    logic [PKT_W-1:0]   r_pkt;
    logic [PKT_W-1:0]   w_pkt_nxt;
    logic               r_long;
    logic               w_long_nxt;
    logic               r_sync_pend;
    logic               w_sync_pend_nxt;
    logic [IVL_W-1:0]   r_ivl_cnt;
    logic [IVL_W-1:0]   w_ivl_cnt_nxt;
    logic               w_ff_done;
    logic               w_active;
    logic               w_expire;
    logic               w_sync_set;
    logic [IDX_W-1:0]   w_last_idx;

    assign w_last_idx = r_long ? LAST_LONG : LAST_SHORT;

    // Next-state and stream outputs; the packet register shifts right one byte per transfer.
    always_comb begin
        w_state_nxt       = r_state;
        w_null_cnt_nxt    = r_null_cnt;
        w_byte_idx_nxt    = r_byte_idx;
        w_pkt_nxt         = r_pkt;
        w_long_nxt        = r_long;
        w_ff_done         = 1'b0;
        PKT_RDY_OUT       = 1'b0;
        BYTE_VLD_OUT      = 1'b0;
        BYTE_DATA_OUT     = 8'h00;
        SYNCHRONISING_OUT = 1'b0;
        case (r_state)
            SYNC_NULL: begin
                BYTE_VLD_OUT      = 1'b1;
                SYNCHRONISING_OUT = 1'b1;
                if (BYTE_RDY_IN) begin
                    if (r_null_cnt >= LAST_NULL) begin
                        w_null_cnt_nxt = '0;
                        w_state_nxt    = SYNC_FF;
                    end else begin
                        w_null_cnt_nxt = r_null_cnt + NULL_W'(1);
                    end
                end
            end
            SYNC_FF: begin
                BYTE_VLD_OUT      = 1'b1;
                BYTE_DATA_OUT     = 8'hFF;
                SYNCHRONISING_OUT = 1'b1;
                if (BYTE_RDY_IN) begin
                    w_ff_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (r_sync_pend) begin
                    w_null_cnt_nxt = '0;
                    w_state_nxt    = SYNC_NULL;
                end else begin
                    PKT_RDY_OUT = 1'b1;
                    if (PKT_VLD_IN) begin
                        w_pkt_nxt      = PKT_DATA_IN;
                        w_long_nxt     = PKT_DATA_IN[1];
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = PKT;
                    end
                end
            end
            PKT: begin
                BYTE_VLD_OUT  = 1'b1;
                BYTE_DATA_OUT = r_pkt[7:0];
                if (BYTE_RDY_IN) begin
                    w_pkt_nxt = r_pkt >> 8;
                    if (r_byte_idx >= w_last_idx) begin
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_null_cnt_nxt = '0;
                w_byte_idx_nxt = '0;
                w_state_nxt    = SYNC_NULL;
            end
        endcase
    end

    // Sync-pending flag and interval timer; a request landing on the final FF survives the clear.
    always_comb begin
        w_active   = (r_state == IDLE) || (r_state == PKT);
        w_expire   = IVL_EN && w_active && ((r_ivl_cnt + IVL_W'(1)) >= IVL_LAST);
        w_sync_set = (SYNC_REQ_IN && w_active) || w_expire;

        w_sync_pend_nxt = r_sync_pend;
        if (w_ff_done) begin
            w_sync_pend_nxt = SYNC_REQ_IN;
        end else if (w_sync_set) begin
            w_sync_pend_nxt = 1'b1;
        end

        w_ivl_cnt_nxt = r_ivl_cnt;
        if (w_ff_done) begin
            w_ivl_cnt_nxt = '0;
        end else if (IVL_EN && w_active && (r_ivl_cnt < IVL_LAST)) begin
            w_ivl_cnt_nxt = r_ivl_cnt + IVL_W'(1);
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RESET_IN) begin
            r_state     <= SYNC_NULL;
            r_null_cnt  <= '0;
            r_byte_idx  <= '0;
            r_pkt       <= '0;
            r_long      <= 1'b0;
            r_sync_pend <= 1'b0;
            r_ivl_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_null_cnt  <= w_null_cnt_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_pkt       <= w_pkt_nxt;
            r_long      <= w_long_nxt;
            r_sync_pend <= w_sync_pend_nxt;
            r_ivl_cnt   <= w_ivl_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_spio_uart_tx_scheduler.sv
// Bench for spio_uart_tx_scheduler: byte-stream scoreboard plus interval timing
// on a second instance built with SYNC_INTERVAL=100.
module tb_spio_uart_tx_scheduler;
    localparam int unsigned N_NULLS = 16;
    localparam int unsigned IVL     = 100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [71:0] pkt_data;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic        sync_req;
    logic [7:0]  byte_data;
    logic        byte_vld;
    logic        byte_rdy;
    logic        syncing;

    logic        iv_rst_n;
    logic        iv_pkt_rdy;
    logic        iv_sync_req;
    logic [7:0]  iv_byte_data;
    logic        iv_byte_vld;
    logic        iv_syncing;

    spio_uart_tx_scheduler #(.NUM_SYNC_NULLS(N_NULLS), .SYNC_INTERVAL(0)) u_dut (
        .CLK_IN(clk), .RESET_IN(rst_n),
        .PKT_DATA_IN(pkt_data), .PKT_VLD_IN(pkt_vld), .PKT_RDY_OUT(pkt_rdy),
        .SYNC_REQ_IN(sync_req),
        .BYTE_DATA_OUT(byte_data), .BYTE_VLD_OUT(byte_vld), .BYTE_RDY_IN(byte_rdy),
        .SYNCHRONISING_OUT(syncing)
    );

    spio_uart_tx_scheduler #(.NUM_SYNC_NULLS(N_NULLS), .SYNC_INTERVAL(IVL)) u_dut_iv (
        .CLK_IN(clk), .RESET_IN(iv_rst_n),
        .PKT_DATA_IN(72'h0), .PKT_VLD_IN(1'b0), .PKT_RDY_OUT(iv_pkt_rdy),
        .SYNC_REQ_IN(iv_sync_req),
        .BYTE_DATA_OUT(iv_byte_data), .BYTE_VLD_OUT(iv_byte_vld), .BYTE_RDY_IN(1'b1),
        .SYNCHRONISING_OUT(iv_syncing)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    logic        prev_stall;
    logic [7:0]  prev_data;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, inputs may change just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (prev_stall) begin
            check("hold_vld", {71'h0, byte_vld}, 72'h1);
            check("hold_data", {64'h0, byte_data}, {64'h0, prev_data});
        end
        prev_stall = byte_vld && !byte_rdy && rst_n;
        prev_data  = byte_data;
        if (byte_vld && byte_rdy && rst_n) obs_q.push_back(byte_data);
        @(posedge clk);
        #1;
    endtask

    task automatic exp_sync();
        repeat (N_NULLS) exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
    endtask

    task automatic exp_pkt(input logic [71:0] p);
        int n = p[1] ? 9 : 5;
        for (int k = 0; k < n; k++) exp_q.push_back(p[8*k +: 8]);
    endtask

    task automatic compare_streams(input string tag);
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        check({tag, "_len"}, 72'(obs_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), {64'h0, obs_q[i]}, {64'h0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    // rdy_mode: 0..100 = percent chance of ready each cycle, >100 = alternate 1/0.
    task automatic run_until_idle(input string tag, input int rdy_mode);
        int n = 0;
        logic tog = 1'b0;
        do begin
            if (rdy_mode > 100) begin
                tog = !tog;
                byte_rdy = tog;
            end else begin
                byte_rdy = (int'($urandom_range(99)) < rdy_mode);
            end
            tick();
            n++;
        end while (!pkt_rdy && n < 2000);
        check({tag, "_idle"}, {71'h0, pkt_rdy}, 72'h1);
        byte_rdy = 1'b1;
    endtask

    task automatic send_pkt(input string tag, input logic [71:0] p);
        check({tag, "_rdy"}, {71'h0, pkt_rdy}, 72'h1);
        pkt_data = p;
        pkt_vld  = 1'b1;
        tick();
        pkt_vld  = 1'b0;
        pkt_data = {$urandom, $urandom, 8'(($urandom))};
        check({tag, "_lat_vld"}, {71'h0, byte_vld}, 72'h1);
        check({tag, "_lat_data"}, {64'h0, byte_data}, {64'h0, p[7:0]});
        exp_pkt(p);
    endtask

    // Counts sync-high cycles then non-sync cycles up to the next sync, pulsing a request at gap index pulse_at.
    task automatic iv_measure(input int pulse_at, output int s, output int g);
        s = 0;
        g = 0;
        while (iv_syncing && s < 200) begin
            s++;
            tick();
        end
        while (!iv_syncing && g < 1000) begin
            iv_sync_req = (g == pulse_at);
            g++;
            tick();
        end
        iv_sync_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] p;
        logic [71:0] p2;
        int          sc;
        int          n;
        int          seen;
        int          s;
        int          g;

        rst_n = 1'b0; iv_rst_n = 1'b0; pkt_vld = 1'b0; pkt_data = '0;
        sync_req = 1'b0; byte_rdy = 1'b1; iv_sync_req = 1'b0;
        prev_stall = 1'b0; prev_data = 8'h00;
        @(posedge clk);
        #1;

        // Reset release and the initial sync sequence
        do_reset(3);
        check("rst_vld", {71'h0, byte_vld}, 72'h1);
        check("rst_data", {64'h0, byte_data}, 72'h0);
        check("rst_sync", {71'h0, syncing}, 72'h1);
        check("rst_pkt_rdy", {71'h0, pkt_rdy}, 72'h0);
        sc = 0;
        n  = 0;
        while (!pkt_rdy && n < 200) begin
            if (syncing) sc++;
            tick();
            n++;
        end
        check("sync_cycles", 72'(sc), 72'(N_NULLS + 1));
        check("post_sync_rdy", {71'h0, pkt_rdy}, 72'h1);
        check("idle_vld", {71'h0, byte_vld}, 72'h0);
        exp_sync();
        compare_streams("rst_seq");

        // Short packet
        send_pkt("short", 72'h12_3456_7800);
        run_until_idle("short", 100);
        compare_streams("short_seq");

        // Long packet with a toggling transmitter ready
        p = {$urandom, $urandom, 8'($urandom)};
        p[1] = 1'b1;
        byte_rdy = 1'b1;
        send_pkt("long_tog", p);
        run_until_idle("long_tog", 200);
        compare_streams("long_tog_seq");

        // Random packets, random ready, random gaps
        for (int i = 0; i < 25; i++) begin
            p = {$urandom, $urandom, 8'($urandom)};
            byte_rdy = ($urandom_range(1) == 1);
            send_pkt("rnd", p);
            run_until_idle("rnd", 30 + int'($urandom_range(70)));
            repeat ($urandom_range(3)) tick();
        end
        compare_streams("rnd_seq");

        // Sync request during byte 2 of a long packet; a waiting packet must yield to the sync
        p = {$urandom, $urandom, 8'($urandom)};
        p[1] = 1'b1;
        p2 = {$urandom, $urandom, 8'($urandom)};
        byte_rdy = 1'b1;
        send_pkt("mid_sync", p);
        tick();
        tick();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        pkt_data = p2;
        pkt_vld  = 1'b1;
        seen = 0;
        n = 0;
        while (obs_q.size() < 9 + N_NULLS + 1 && n < 300) begin
            if (pkt_rdy) seen++;
            tick();
            n++;
        end
        check("mid_sync_rdy_low", 72'(seen), 72'h0);
        tick();
        pkt_vld = 1'b0;
        exp_sync();
        exp_pkt(p2);
        run_until_idle("mid_sync", 100);
        compare_streams("mid_sync_seq");

        // Request during the null bytes is absorbed
        do_reset(1);
        byte_rdy = 1'b1;
        repeat (5) tick();
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        run_until_idle("absorb", 100);
        seen = 0;
        repeat (5) begin
            tick();
            if (syncing) seen++;
        end
        check("absorb_nosync", 72'(seen), 72'h0);
        exp_sync();
        compare_streams("absorb_seq");

        // Request coincident with the final FF transfer yields a second sequence
        do_reset(1);
        byte_rdy = 1'b1;
        repeat (N_NULLS) tick();
        check("ff_presented", {64'h0, byte_data}, 72'hFF);
        sync_req = 1'b1;
        tick();
        sync_req = 1'b0;
        check("ff_coinc_rdy", {71'h0, pkt_rdy}, 72'h0);
        run_until_idle("ff_coinc", 100);
        exp_sync();
        exp_sync();
        compare_streams("ff_coinc_seq");

        // Reset mid-packet abandons the packet and restarts a full sync
        p = {$urandom, $urandom, 8'($urandom)};
        p[1] = 1'b1;
        byte_rdy = 1'b1;
        send_pkt("rst_mid", p);
        repeat (3) tick();
        do_reset(1);
        check("rst_mid_data", {64'h0, byte_data}, 72'h0);
        check("rst_mid_sync", {71'h0, syncing}, 72'h1);
        check("rst_mid_vld", {71'h0, byte_vld}, 72'h1);
        run_until_idle("rst_mid", 100);
        repeat (4) tick();
        exp_sync();
        compare_streams("rst_mid_seq");

        // Automatic re-sync every IVL non-sync cycles
        iv_rst_n = 1'b0;
        repeat (2) tick();
        iv_rst_n = 1'b1;
        check("iv_rst_sync", {71'h0, iv_syncing}, 72'h1);
        for (int r = 0; r < 2; r++) begin
            iv_measure(-1, s, g);
            check($sformatf("iv_sync_len%0d", r), 72'(s), 72'(N_NULLS + 1));
            check($sformatf("iv_gap%0d", r), 72'(g), 72'(IVL));
        end
        // Request on the cycle the interval lapses: one sequence, then a full interval again
        iv_measure(int'(IVL) - 2, s, g);
        check("iv_coinc_len", 72'(s), 72'(N_NULLS + 1));
        check("iv_coinc_gap", 72'(g), 72'(IVL));
        iv_measure(-1, s, g);
        check("iv_after_len", 72'(s), 72'(N_NULLS + 1));
        check("iv_after_gap", 72'(g), 72'(IVL));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
